// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/regfile/ALU/memory for the supported
// subset, waits on mem_ready, counts retired instructions and halts on illegal encodings.
module mips_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       PCSrc,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_R_EXEC,
    S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwr;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       halt;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d, fn_q, fn_d;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_inc;
  logic              fetch_go;
  logic              unused_zero;

  // Branch resolution happens in the datapath via PCWriteCond; the flag is not needed here.
  assign unused_zero = zero;

  function automatic logic [2:0] r_aluop(input logic [5:0] fn);
    case (fn)
      6'b100010: r_aluop = 3'b011;
      6'b100100: r_aluop = 3'b000;
      6'b100101: r_aluop = 3'b001;
      6'b101010: r_aluop = 3'b100;
      default:   r_aluop = 3'b010;
    endcase
  endfunction

  function automatic logic r_legal(input logic [5:0] fn);
    r_legal = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
              (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  // Outputs are registered from the state being entered, so they line up with state_q.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 3'b010; end
      S_DECODE:    begin c.srcb = 2'b11; c.aluop = 3'b010; end
      S_MEM_ADDR:  begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b010; end
      S_MEM_READ:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.memtoreg = 2'b01; c.regwr = 1'b1; end
      S_MEM_WRITE: begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_R_EXEC:    begin c.srca = 1'b1; c.aluop = r_aluop(fn); end
      S_R_WB:      begin c.regdst = 2'b01; c.regwr = 1'b1; end
      S_I_EXEC:    begin
        c.srca  = 1'b1;
        c.srcb  = 2'b10;
        c.aluop = (op == OP_SLTI) ? 3'b100 : 3'b010;
      end
      S_I_WB:      c.regwr = 1'b1;
      S_BRANCH:    begin c.srca = 1'b1; c.aluop = 3'b011; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
      S_JUMP:      begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
      S_JAL:       begin
        c.pcw      = 1'b1;
        c.pcsrc    = 2'b10;
        c.regwr    = 1'b1;
        c.regdst   = 2'b10;
        c.memtoreg = 2'b10;
      end
      S_JR:        begin c.pcw = 1'b1; c.pcsrc = 2'b11; end
      S_HALT:      c.halt = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        fn_d = funct;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR :
                                      r_legal(funct) ? S_R_EXEC : S_HALT;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:     state_d = state_q;
    endcase
    cnt_inc = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      ctrl_q  <= decode_ctrl(state_d, op_d, fn_d);
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fetch_go     = (state_q == S_FETCH) && mem_ready;
  assign IRWrite      = fetch_go;
  assign PCWrite      = ctrl_q.pcw | fetch_go;
  assign PCWriteCond  = ctrl_q.pcwc;
  assign IorD         = ctrl_q.iord;
  assign MemRead      = ctrl_q.mrd;
  assign MemWrite     = ctrl_q.mwr;
  assign RegDst       = ctrl_q.regdst;
  assign MemToReg     = ctrl_q.memtoreg;
  assign RegWrite     = ctrl_q.regwr;
  assign ALUSrcA      = ctrl_q.srca;
  assign ALUSrcB      = ctrl_q.srcb;
  assign ALUOperation = ctrl_q.aluop;
  assign PCSrc        = ctrl_q.pcsrc;
  assign halted       = ctrl_q.halt;
  assign state        = state_q;
  assign instr_count  = cnt_q;

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Moore-style FSM controller (with memory-ready gating) for the multi-cycle MIPS datapath. It shares one memory port and one ALU across fetch, execute and memory phases. It sequences the PC, IR, register file, ALU-source muxes and unified memory for the instruction subset R-type (add, sub, and, or, slt, jr), addi, slti, lw, sw, beq, j and jal. It also counts retired instructions and halts on illegal encodings.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if zero=1
IorD  out  1  0=PC, 1=ALUOut drives memory address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
RegDst  out  2  00 rt, 01 rd, 10 $31
MemToReg  out  2  00 ALUOut, 01 MDR, 10 PC
RegWrite  out  1  register file write
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 signext, 11 signext<<2
ALUOperation  out  3  000 and, 001 or, 010 add, 011 sub, 100 slt
PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A
halted  out  1  controller in HALT
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset: rst=0 forces state=IDLE(0) asynchronously and clears instr_count and the latched opcode/funct. In IDLE every control output is 0 and halted=0. The first rising edge with rst=1 moves IDLE to FETCH.
- Outputs depend only on state and latched opcode/funct, except IRWrite, PCWrite in FETCH and the wait transitions, which are gated by mem_ready. Unlisted outputs are 0 in every state.
- State encodings and outputs:
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=010, PCSrc=00, IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(2): latch opcode and funct. ALUSrcA=0, ALUSrcB=11, ALUOperation=010 (branch target into ALUOut). Next state: lw/sw→MEM_ADDR, R-type with legal funct other than jr→R_EXEC, R-type funct 001000→JR, addi/slti→I_EXEC, beq→BRANCH, j→JUMP, jal→JAL, anything else→HALT.
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOperation=010. Next state is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(4): MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEM_WB.
  - MEM_WB(5): RegDst=00, MemToReg=01, RegWrite=1. Next state FETCH.
  - MEM_WRITE(6): MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
  - R_EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOperation from funct (add 100000→010, sub 100010→011, and 100100→000, or 100101→001, slt 101010→100). Next state R_WB.
  - R_WB(8): RegDst=01, MemToReg=00, RegWrite=1. Next state FETCH.
  - I_EXEC(9): ALUSrcA=1, ALUSrcB=10, ALUOperation=010 (addi 001000) or 100 (slti 001010). Next state I_WB.
  - I_WB(10): RegDst=00, MemToReg=00, RegWrite=1. Next state FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOperation=011, PCWriteCond=1, PCSrc=01. Next state FETCH.
  - JUMP(12): PCWrite=1, PCSrc=10. Next state FETCH.
  - JAL(13): PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemToReg=10. Next state FETCH.
  - JR(14): PCWrite=1, PCSrc=11. Next state FETCH.
  - HALT(15): all control outputs 0, halted=1. Absorbing until reset.
- Retirement: instr_count increments by 1 on every transition into FETCH from any state other than IDLE, and wraps to 0 with no flag. HALT does not increment the counter.
- Latency with mem_ready held at 1: R-type and addi/slti 4 cycles; lw 5; sw 4; beq, j, jal and jr 3. Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- MemRead and MemWrite are never asserted in the same cycle. RegWrite and MemWrite are never asserted in the same cycle.
- Reset asserted mid-instruction (including during a memory wait) aborts to IDLE immediately. No write strobes are asserted after reset.
- opcode and funct changes after DECODE are ignored; the latched copies are used.

Test Plan:
- Reset release with mem_ready=1, opcode=000000, funct=100000 → IDLE, FETCH, DECODE, R_EXEC (ALUOperation=010), R_WB (RegWrite=1, RegDst=01), FETCH; instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → IRWrite pulses exactly once; total 10 cycles FETCH to FETCH; MEM_WB drives MemToReg=01.
- beq (000100), once with zero=1 and once with zero=0 → BRANCH asserts PCWriteCond=1 and PCSrc=01 in both runs; 3 cycles each; count increments by 2.
- jal (000011), then R-type funct 001000 → JAL asserts RegDst=10, MemToReg=10, PCWrite=1, PCSrc=10; JR asserts PCSrc=11.
- Illegal opcode 111111, and R-type funct 000111 after a reset → each run reaches HALT with halted=1 and all strobes 0; instr_count stays unchanged over 20 cycles.
- rst driven low during the MEM_WRITE wait → state=0 and MemWrite=0 asynchronously; instr_count=0; after release the controller restarts at FETCH.
